// File: rtl/window_gen3x3.sv
// Streaming 3x3 window generator for a three-channel raster pixel stream.
// Per-channel shift-register line buffers feed a zero-padded neighbourhood
// that is packed {p8..p0} per channel and registered on o_busData0/1/2.
module window_gen3x3 #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_data0,
  input  logic [DATA_W-1:0]     i_data1,
  input  logic [DATA_W-1:0]     i_data2,
  output logic                  o_valid,
  output logic [9*DATA_W-1:0]   o_busData0,
  output logic [9*DATA_W-1:0]   o_busData1,
  output logic [9*DATA_W-1:0]   o_busData2,
  output logic                  o_last
);

  // The oldest tap (2*IMG_W+2) is never stored: it is the previous content of
  // tap 2*IMG_W+1 and goes straight into the output register as p0.
  localparam int unsigned Taps = 2 * IMG_W + 2;
  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam int unsigned PixW = $clog2(NPix);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned FlW  = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {StFill, StStream, StFlush} stateT;

  stateT             state;
  logic [PixW-1:0]   pixCnt;
  logic [RowW-1:0]   outRow;
  logic [ColW-1:0]   outCol;
  logic [FlW-1:0]    flushCnt;

  logic [DATA_W-1:0] lineBuf [3][Taps];
  logic [DATA_W-1:0] inPix   [3];
  logic [DATA_W-1:0] raw     [3][9];
  logic [9*DATA_W-1:0] winBus [3];
  logic [8:0]        keep;

  logic accept, shiftEn, winFire;
  logic atTop, atBot, atLeft, atRight;

  assign o_ready = i_rst_n && (state != StFlush);
  assign accept  = i_valid && o_ready;
  assign shiftEn = accept || (state == StFlush);
  assign winFire = (accept && (state == StStream)) || (state == StFlush);

  assign atTop   = (outRow == '0);
  assign atBot   = (outRow == RowW'(IMG_H - 1));
  assign atLeft  = (outCol == '0);
  assign atRight = (outCol == ColW'(IMG_W - 1));

  // Incoming sample per channel; zeros are shifted in while flushing.
  always_comb begin
    inPix[0] = (state == StFlush) ? '0 : i_data0;
    inPix[1] = (state == StFlush) ? '0 : i_data1;
    inPix[2] = (state == StFlush) ? '0 : i_data2;
  end

  // Window taps as they will be after this shift, masked at the frame border.
  always_comb begin
    keep[0] = !atTop && !atLeft;
    keep[1] = !atTop;
    keep[2] = !atTop && !atRight;
    keep[3] = !atLeft;
    keep[4] = 1'b1;
    keep[5] = !atRight;
    keep[6] = !atBot && !atLeft;
    keep[7] = !atBot;
    keep[8] = !atBot && !atRight;
    for (int ch = 0; ch < 3; ch++) begin
      raw[ch][8] = inPix[ch];
      raw[ch][7] = lineBuf[ch][0];
      raw[ch][6] = lineBuf[ch][1];
      raw[ch][5] = lineBuf[ch][IMG_W-1];
      raw[ch][4] = lineBuf[ch][IMG_W];
      raw[ch][3] = lineBuf[ch][IMG_W+1];
      raw[ch][2] = lineBuf[ch][2*IMG_W-1];
      raw[ch][1] = lineBuf[ch][2*IMG_W];
      raw[ch][0] = lineBuf[ch][2*IMG_W+1];
      winBus[ch] = '0;
      for (int p = 0; p < 9; p++) begin
        if (keep[p]) winBus[ch][p*DATA_W +: DATA_W] = raw[ch][p];
      end
    end
  end

  // Line buffers: shift on every accepted pixel and every flush cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        for (int t = 0; t < int'(Taps); t++) lineBuf[ch][t] <= '0;
      end
    end else if (shiftEn) begin
      for (int ch = 0; ch < 3; ch++) begin
        lineBuf[ch][0] <= inPix[ch];
        for (int t = 1; t < int'(Taps); t++) lineBuf[ch][t] <= lineBuf[ch][t-1];
      end
    end
  end

  // Fill/stream/flush control, centre counters and registered window outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= StFill;
      pixCnt     <= '0;
      outRow     <= '0;
      outCol     <= '0;
      flushCnt   <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_busData0 <= '0;
      o_busData1 <= '0;
      o_busData2 <= '0;
    end else begin
      o_valid <= winFire;
      o_last  <= winFire && atBot && atRight;
      if (winFire) begin
        o_busData0 <= winBus[0];
        o_busData1 <= winBus[1];
        o_busData2 <= winBus[2];
        if (atRight) begin
          outCol <= '0;
          outRow <= outRow + RowW'(1);
        end else begin
          outCol <= outCol + ColW'(1);
        end
      end
      unique case (state)
        StFill: begin
          if (accept) begin
            pixCnt <= pixCnt + PixW'(1);
            if (pixCnt == PixW'(IMG_W)) state <= StStream;
          end
        end
        StStream: begin
          if (accept) begin
            if (pixCnt == PixW'(NPix - 1)) begin
              state    <= StFlush;
              pixCnt   <= '0;
              flushCnt <= '0;
            end else begin
              pixCnt <= pixCnt + PixW'(1);
            end
          end
        end
        StFlush: begin
          if (flushCnt == FlW'(IMG_W)) begin
            state    <= StFill;
            flushCnt <= '0;
            outRow   <= '0;
            outCol   <= '0;
          end else begin
            flushCnt <= flushCnt + FlW'(1);
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_window_gen3x3.sv
// Scoreboard bench for window_gen3x3: stimulus queues expected windows from a
// coordinate-based padding model; a monitor pops and compares on o_valid.
module tb_window_gen3x3;

  localparam int DW   = 10;
  localparam int W    = 64;
  localparam int H    = 64;
  localparam int NPIX = W * H;
  localparam int BW   = 9 * DW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data0 = '0, i_data1 = '0, i_data2 = '0;
  logic          o_valid;
  logic [BW-1:0] o_busData0, o_busData1, o_busData2;
  logic          o_last;

  window_gen3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .o_valid    (o_valid),
    .o_busData0 (o_busData0),
    .o_busData1 (o_busData1),
    .o_busData2 (o_busData2),
    .o_last     (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [BW-1:0] b0, b1, b2;
    logic          last;
    int            idx;
    int            off;
  } expT;

  expT sb[$];
  int  errCnt = 0;
  int  chkCnt = 0;
  int  lastCnt = 0;

  int h00 [9] = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
  int h11 [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
  int hEnd[9] = '{958, 959, 0, 1022, 1023, 0, 0, 0, 0};
  int h563[9] = '{318, 319, 0, 382, 383, 0, 446, 447, 0};
  int h60 [9] = '{0, 320, 321, 0, 384, 385, 0, 448, 449};
  int h00o7[9] = '{0, 0, 0, 0, 7, 8, 0, 71, 72};

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic handChk(input string name, input logic [BW-1:0] bus, input int h[9]);
    for (int p = 0; p < 9; p++) begin
      chk($sformatf("%s_p%0d", name, p), BW'(bus[p*DW +: DW]), BW'(h[p]));
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c, input int ch, input int off);
    if (r < 0 || r >= H || c < 0 || c >= W) return '0;
    return DW'((r * W + c + ch + off) % 1024);
  endfunction

  function automatic logic [BW-1:0] win(input int r, input int c, input int ch, input int off);
    logic [BW-1:0] b;
    b = '0;
    for (int p = 0; p < 9; p++) b[p*DW +: DW] = pix(r + p / 3 - 1, c + p % 3 - 1, ch, off);
    return b;
  endfunction

  // Monitor: at each falling edge, account for the accept on the edge just
  // passed, then score any window presented.
  initial begin
    int  accCnt;
    bit  willAcc;
    expT e;
    accCnt  = 0;
    willAcc = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        accCnt  = 0;
        willAcc = 1'b0;
      end else begin
        if (willAcc) accCnt++;
        if (o_valid) begin
          if (sb.size() == 0) begin
            chk("extra_window", BW'(1), BW'(0));
          end else begin
            e = sb.pop_front();
            chk($sformatf("bus0_i%0d", e.idx), o_busData0, e.b0);
            chk($sformatf("bus1_i%0d", e.idx), o_busData1, e.b1);
            chk($sformatf("bus2_i%0d", e.idx), o_busData2, e.b2);
            chk($sformatf("last_i%0d", e.idx), BW'(o_last), BW'(e.last));
            if (e.idx < NPIX - W - 1) chk("stream_needs_accept", BW'(willAcc), BW'(1));
            if (e.idx == 0) chk("first_win_latency", BW'(accCnt), BW'(W + 2));
            if (e.off == 0) begin
              if (e.idx == 0)    handChk("w00", o_busData0, h00);
              if (e.idx == 65)   begin
                handChk("w11", o_busData0, h11);
                chk("w11_ch1_p4", BW'(o_busData1[4*DW +: DW]), BW'(66));
                chk("w11_ch2_p4", BW'(o_busData2[4*DW +: DW]), BW'(67));
              end
              if (e.idx == 383)  handChk("w5_63", o_busData0, h563);
              if (e.idx == 384)  handChk("w6_0", o_busData0, h60);
              if (e.idx == 4095) handChk("w63_63", o_busData0, hEnd);
            end
            if (e.off == 7 && e.idx == 0) handChk("w00_off7", o_busData0, h00o7);
          end
          if (o_last) begin
            lastCnt++;
            chk("ready_with_last", BW'(o_ready), BW'(1));
            accCnt = 0;
          end
        end
        willAcc = i_valid && o_ready;
      end
    end
  end

  task automatic sendPix(input int k, input int off, output int waited);
    waited = 0;
    i_valid = 1'b1;
    i_data0 = DW'((k + off) % 1024);
    i_data1 = DW'((k + 1 + off) % 1024);
    i_data2 = DW'((k + 2 + off) % 1024);
    while (!o_ready && waited < 200) begin
      @(posedge i_clk); #1;
      waited++;
    end
    if (!o_ready) chk("ready_timeout", BW'(0), BW'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic runFrame(input int off, input int nPix, input bit gaps);
    expT e;
    int  waited, lowCnt;
    for (int i = 0; i < NPIX; i++) begin
      e.b0 = win(i / W, i % W, 0, off);
      e.b1 = win(i / W, i % W, 1, off);
      e.b2 = win(i / W, i % W, 2, off);
      e.last = (i == NPIX - 1);
      e.idx = i;
      e.off = off;
      sb.push_back(e);
    end
    for (int k = 0; k < nPix; k++) begin
      if (gaps) begin
        i_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
      end
      sendPix(k, off, waited);
      if (k == 0) chk("pix0_no_wait", BW'(waited), BW'(0));
    end
    if (nPix == NPIX) begin
      // Hold a bogus pixel during flush; it must be ignored.
      i_valid = 1'b1;
      i_data0 = '1; i_data1 = '1; i_data2 = '1;
      lowCnt = 0;
      while (!o_ready && lowCnt < 200) begin
        lowCnt++;
        @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      chk("ready_low_cycles", BW'(lowCnt), BW'(W + 1));
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", BW'(o_valid), BW'(0));
    chk("rst_last", BW'(o_last), BW'(0));
    chk("rst_ready", BW'(o_ready), BW'(0));
    chk("rst_bus0", o_busData0, '0);
    chk("rst_bus1", o_busData1, '0);
    chk("rst_bus2", o_busData2, '0);
    i_rst_n = 1'b1;
    #1;
    chk("ready_after_rst", BW'(o_ready), BW'(1));

    runFrame(0, NPIX, 1'b0);
    runFrame(7, NPIX, 1'b0);
    runFrame(0, NPIX, 1'b1);

    // Abandon a frame at pixel 2000 with a reset.
    runFrame(0, 2000, 1'b0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("ready_in_rst", BW'(o_ready), BW'(0));
    end
    chk("rst_mid_valid", BW'(o_valid), BW'(0));
    sb.delete();
    i_rst_n = 1'b1;
    #1;
    runFrame(0, NPIX, 1'b0);

    repeat (5) @(posedge i_clk);
    #1;
    chk("sb_drained", BW'(sb.size()), BW'(0));
    chk("last_count", BW'(lastCnt), BW'(4));
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
